// File: rtl/dmem_cache.sv
// dmem_cache: direct-mapped write-through no-write-allocate MEM-stage data cache.
// Optional hit/miss counters are enabled by defining DMEM_CACHE_STATS_EN.
`timescale 1ns/1ps
module dmem_cache #(
  parameter int LINES  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
`ifdef DMEM_CACHE_STATS_EN
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count,
`endif
  input  logic              mem_ack
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  typedef enum logic [1:0] {
    IDLE,
    RD_MISS,
    WR_THRU,
    WR_DONE
  } state_t;

  state_t state;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic             hit;
  logic             ack;
  logic             st_req;
  logic             ld_req;
  logic             ld_miss;
  logic             unused_addr;

  assign idx      = addr[IDX_W+1:2];
  assign tag      = addr[ADDR_W-1:IDX_W+2];
  assign fill_idx = mem_addr[IDX_W+1:2];
  assign fill_tag = mem_addr[ADDR_W-1:IDX_W+2];
  assign hit      = valid_q[idx] && (tag_q[idx] == tag);

  // Ack only counts while a request is outstanding.
  assign ack      = mem_req & mem_ack;

  assign st_req   = (state == IDLE) & mem_write;
  assign ld_req   = (state == IDLE) & mem_read & ~mem_write;
  assign ld_miss  = ld_req & ~hit;

  assign unused_addr = ^addr[1:0];

  // Pipeline freeze; forced low while reset is held.
  always_comb begin
    stall = 1'b0;
    if (rst) begin
      case (state)
        IDLE:    stall = mem_write | (mem_read & ~hit);
        RD_MISS: stall = 1'b1;
        WR_THRU: stall = 1'b1;
        default: stall = 1'b0;
      endcase
    end
  end

  // Zero-latency load hit data; zero otherwise.
  always_comb begin
    read_data = 32'h0;
    if (rst && ld_req && hit)
      read_data = data_q[idx];
  end

  // Control FSM with registered backing-memory request and valid bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      valid_q   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (st_req) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
            mem_wdata <= write_data;
            state     <= WR_THRU;
          end else if (ld_miss) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
            state     <= RD_MISS;
          end
        end
        RD_MISS: begin
          if (ack) begin
            valid_q[fill_idx] <= 1'b1;
            mem_req           <= 1'b0;
            state             <= IDLE;
          end
        end
        WR_THRU: begin
          if (ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= WR_DONE;
          end
        end
        WR_DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag/data storage; contents are qualified by valid_q so need no reset.
  always_ff @(posedge clk) begin
    if (st_req && hit)
      data_q[idx] <= write_data;
    if ((state == RD_MISS) && ack) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mem_rdata;
    end
  end

`ifdef DMEM_CACHE_STATS_EN
  logic fill_q;

  // The release cycle after a fill belongs to the missed load, not a new hit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_q <= 1'b0;
    end else begin
      fill_q <= (state == RD_MISS) & ack;
    end
  end

  // Saturating hit/miss counters for loads only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count  <= 32'h0;
      miss_count <= 32'h0;
    end else begin
      if (ld_req && hit && !fill_q && (hit_count != 32'hFFFF_FFFF))
        hit_count <= hit_count + 32'd1;
      if (ld_miss && (miss_count != 32'hFFFF_FFFF))
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_cache.sv
// tb_dmem_cache: scoreboard bench with random loads/stores and a
// residency-map model of the cache over a word-addressed backing store.
`timescale 1ns/1ps
module tb_dmem_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
`ifdef DMEM_CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  always #5 clk = ~clk;

  dmem_cache #(.LINES(16), .ADDR_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .addr(addr),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .write_data(write_data),
    .read_data(read_data),
    .stall(stall),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
`ifdef DMEM_CACHE_STATS_EN
    .hit_count(hit_count),
    .miss_count(miss_count),
`endif
    .mem_ack(mem_ack)
  );

  typedef struct {
    bit          we;
    logic [31:0] a;
    logic [31:0] wd;
  } req_t;

  typedef struct {
    bit          store;
    logic [31:0] data;
    int          stalls;
  } op_t;

  req_t req_q[$];
  op_t  op_q[$];
  int   dly_q[$];

  logic [31:0] backing [bit [31:0]];
  logic [31:0] resident [int];

  int vectors = 0;
  int miscompares = 0;
  bit mon_en = 1'b0;
  bit prev_req = 1'b0;
  int scnt = 0;
  int hits_m = 0;
  int miss_m = 0;

  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endfunction

  function automatic logic [31:0] mem_val(bit [31:0] a);
    if (backing.exists(a)) return backing[a];
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  // Monitor: pops expected requests and op completions as the DUT shows them.
  initial begin
    req_t r;
    op_t  o;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (mem_req && !prev_req) begin
          if (req_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_req: got addr %h expected none", mem_addr);
          end else begin
            r = req_q.pop_front();
            chk("req_we", 32'(mem_we), 32'(r.we));
            chk("req_addr", mem_addr, r.a);
            if (r.we) chk("req_wdata", mem_wdata, r.wd);
          end
        end
        if (stall) begin
          scnt++;
        end else if (mem_read || mem_write) begin
          if (op_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_done: got completion expected none");
          end else begin
            o = op_q.pop_front();
            chk("stall_cycles", 32'(scnt), 32'(o.stalls));
            chk("read_data", read_data, o.store ? 32'h0 : o.data);
          end
          scnt = 0;
        end else begin
          chk("idle_read_data", read_data, 32'h0);
        end
      end
      prev_req = mem_req;
    end
  end

  // Backing memory responder: acks after the delay the driver queued.
  initial begin
    int d;
    forever begin
      @(negedge clk);
      if (mem_req && !mem_ack) begin
        d = (dly_q.size() != 0) ? dly_q.pop_front() : 0;
        repeat (d) @(negedge clk);
        mem_rdata = mem_val(mem_addr);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        mem_rdata = '0;
      end
    end
  end

  // Issue one op, push its expectations, wait for the stall to release.
  task automatic do_op(input bit wr, input bit rd, input logic [31:0] a,
                       input logic [31:0] wd, input int d);
    logic [31:0] aw;
    int          ix;
    bit          hit;
    bit          done;
    aw  = a & 32'hFFFF_FFFC;
    ix  = int'((aw >> 2) % 16);
    hit = resident.exists(ix) && (resident[ix] == aw);
    if (wr) begin
      backing[aw] = wd;
      req_q.push_back('{1'b1, aw, wd});
      dly_q.push_back(d);
      op_q.push_back('{1'b1, 32'h0, d + 2});
    end else if (rd) begin
      if (hit) begin
        hits_m++;
        op_q.push_back('{1'b0, mem_val(aw), 0});
      end else begin
        miss_m++;
        resident[ix] = aw;
        req_q.push_back('{1'b0, aw, 32'h0});
        dly_q.push_back(d);
        op_q.push_back('{1'b0, mem_val(aw), d + 2});
      end
    end
    addr       = a;
    mem_read   = rd;
    mem_write  = wr;
    write_data = wd;
    done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!stall) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL op_timeout: got stall stuck expected release at addr %h", a);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] a;
    int          r;
    #2 rst = 1'b0;
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_read_data", read_data, 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    backing[32'h40] = 32'hDEAD_BEEF;
    do_op(1'b0, 1'b1, 32'h40, 32'h0, 2);
    do_op(1'b0, 1'b1, 32'h40, 32'h0, 0);
    do_op(1'b1, 1'b0, 32'h40, 32'h1234_5678, 1);
    do_op(1'b0, 1'b1, 32'h40, 32'h0, 0);
    do_op(1'b1, 1'b0, 32'h80, 32'hCAFE_0080, 0);
    do_op(1'b0, 1'b1, 32'h80, 32'h0, 1);
    do_op(1'b0, 1'b1, 32'h40, 32'h0, 0);
    do_op(1'b0, 1'b1, 32'h43, 32'h0, 0);
    do_op(1'b1, 1'b1, 32'h44, 32'h5555_AAAA, 0);
    do_op(1'b0, 1'b1, 32'h44, 32'h0, 3);

    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 9));
      a = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) |
          $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) a = $urandom;
      if (r < 2) begin
        addr = a;
        mem_read = 1'b0;
        mem_write = 1'b0;
        @(posedge clk);
        #1;
      end else if (r < 5) begin
        do_op(1'b1, r == 2, a, $urandom, int'($urandom_range(0, 4)));
      end else begin
        do_op(1'b0, 1'b1, a, 32'h0, int'($urandom_range(0, 4)));
      end
    end

    do_op(1'b0, 1'b1, 32'h40, 32'h0, 0);
    mon_en = 1'b0;
    addr = 32'h1000_0040;
    mem_read = 1'b1;
    mem_write = 1'b0;
    dly_q.push_back(6);
    @(negedge clk);
    @(negedge clk);
    chk("rdmiss_req", 32'(mem_req), 32'h1);
    chk("rdmiss_stall", 32'(stall), 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("abort_req", 32'(mem_req), 32'h0);
    chk("abort_stall", 32'(stall), 32'h0);
    chk("abort_read_data", read_data, 32'h0);
    mem_read = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    resident.delete();
    req_q.delete();
    op_q.delete();
    dly_q.delete();
    scnt = 0;
    hits_m = 0;
    miss_m = 0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    do_op(1'b0, 1'b1, 32'h40, 32'h0, 1);
    do_op(1'b0, 1'b1, 32'h40, 32'h0, 0);
    do_op(1'b0, 1'b1, 32'h40, 32'h0, 0);
    do_op(1'b1, 1'b0, 32'h40, 32'h0BAD_F00D, 0);
    do_op(1'b0, 1'b1, 32'h84, 32'h0, 2);
    do_op(1'b0, 1'b1, 32'h40, 32'h0, 0);
`ifdef DMEM_CACHE_STATS_EN
    chk("hit_count", hit_count, 32'(hits_m));
    chk("miss_count", miss_count, 32'(miss_m));
`endif
    addr = '0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    repeat (3) @(negedge clk);
    if (op_q.size() != 0 || req_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL leftover: got %0d ops %0d reqs expected 0 0",
               op_q.size(), req_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_cache.md
Name: dmem_cache

Overview:
- Direct-mapped, write-through, no-write-allocate data cache for the MEM stage.
- Sits between the EX/MEM pipeline register outputs (address, write data, mem_read/mem_write) and a slower backing data memory reached over a req/ack handshake.
- On a load hit, returns data in the same cycle.
- On a load miss or any store, raises `stall` so the pipeline freezes until the backing memory completes.

Parameters:
- LINES, 16: number of cache lines; power of two, ≥2. One 32-bit word per line. IDX_W = log2(LINES).
- ADDR_W, 32: byte address width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- addr  in  ADDR_W  byte address (ALU result from EX/MEM); bits [1:0] ignored
- mem_read  in  1  load request
- mem_write  in  1  store request
- write_data  in  32  store data
- read_data  out  32  load data to MEM/WB
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- mem_req  out  1  backing-memory request
- mem_we  out  1  backing-memory write (1) / read (0)
- mem_addr  out  ADDR_W  word-aligned backing address; [1:0] = 0
- mem_wdata  out  32  backing write data
- mem_rdata  in  32  backing read data, valid with mem_ack
- mem_ack  in  1  backing completion; sampled only while mem_req=1

Behaviour:
- Address split:
  - index = addr[IDX_W+1:2]
  - tag = addr[ADDR_W-1:IDX_W+2]
  - each line holds valid, tag and data.
- Hit = valid[index] & (tag_array[index] == tag).
- Reset (async, rst=0):
  - all valid bits cleared
  - state=IDLE
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0
  - read_data=0, stall=0
  - an in-flight transaction is abandoned; mem_req drops immediately.
- FSM states: IDLE, RD_MISS, WR_THRU, WR_DONE.
- IDLE:
  - mem_write=1 (priority over mem_read):
    - stall=1 combinationally
    - register mem_req=1, mem_we=1, mem_addr={addr[ADDR_W-1:2],2'b00}, mem_wdata=write_data
    - on a hit, update the line data at the same edge; a miss does not allocate
    - next state WR_THRU.
  - mem_read=1 & hit: read_data = line data combinationally, stall=0, stay IDLE.
  - mem_read=1 & miss:
    - stall=1
    - register mem_req=1, mem_we=0, mem_addr aligned
    - next state RD_MISS.
  - Neither request: stall=0, read_data=0.
- RD_MISS:
  - stall=1; mem_req, mem_addr held stable.
  - On mem_ack: write the line (valid=1, tag, data=mem_rdata), drop mem_req, go to IDLE.
  - The following IDLE cycle hits and releases the stall.
- WR_THRU:
  - stall=1; mem_req, mem_we, mem_addr, mem_wdata held stable.
  - On mem_ack: drop mem_req and mem_we, go to WR_DONE.
- WR_DONE:
  - stall=0 for exactly one cycle; mem_read/mem_write ignored so the same store is not reissued; read_data=0.
  - Next state IDLE.
- Latency:
  - load hit: 0 extra cycles.
  - load miss: stall cycles = 1 + N, where N = cycles in RD_MISS until ack (N≥1; ack in the first RD_MISS cycle gives 2 stall cycles).
  - store: stall cycles = 1 + N, then WR_DONE.
- mem_ack while mem_req=0 is ignored.
- Ack arriving in the same cycle as a further request change is impossible: inputs are frozen by stall.
- Index wrap: addresses differing only in tag conflict; a fill overwrites the line.
- mem_read & mem_write both high: treated as a store only.

Optional Feature:
- Macro: DMEM_CACHE_STATS_EN.
- Defined: adds outputs hit_count (32) and miss_count (32).
  - Both cleared by rst.
  - hit_count increments once per load accepted as a hit in IDLE.
  - miss_count increments once per entry into RD_MISS.
  - Stores are not counted.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: no counter logic and no such ports.

Test Plan:
- Reset, then load addr=0x40:
  - Miss: stall=1, mem_req=1, mem_addr=0x40, mem_we=0.
  - Ack after 3 cycles with mem_rdata=0xDEADBEEF.
  - Next cycle read_data=0xDEADBEEF, stall=0.
  - Repeat load: hit, no mem_req.
- Store 0x12345678 to 0x40 after the fill above:
  - mem_req=1, mem_we=1, mem_wdata=0x12345678.
  - Ack, then one WR_DONE cycle with stall=0.
  - Load 0x40 hits and returns 0x12345678.
- Store to uncached 0x80: write-through only; subsequent load 0x80 misses (no allocate).
- LINES=16, load 0x40 then 0x80 (same index 0, different tag), then 0x40 again: three misses; the second fill evicts the first.
- Assert rst low during RD_MISS before ack: mem_req=0 and stall=0 immediately; previously cached 0x40 now misses.
- With DMEM_CACHE_STATS_EN: sequence miss, hit, hit, store, miss gives hit_count=2, miss_count=2.
